// File: rtl/slice_to_lane_collector.sv
// slice_to_lane_collector
// Collects DEPTH permuted slices of LINE_W bits, transposes them into LINE_W
// lanes of DEPTH bits, then streams the lanes out in index order.
// Optional feature: define SLICE_PARITY_EN to add the in_parity input and the
// sticky parity_err output (even parity checked on every accepted slice).
module slice_to_lane_collector #(
    parameter int unsigned LINE_W = 25,
    parameter int unsigned DEPTH  = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [LINE_W-1:0] in_line,
`ifdef SLICE_PARITY_EN
    input  logic              in_parity,
    output logic              parity_err,
`endif
    output logic              in_ready,
    output logic              out_valid,
    output logic [DEPTH-1:0]  out_lane,
    output logic [4:0]        out_idx,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    localparam int unsigned CNT_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_slice_cnt;
    logic [4:0]         r_lane_cnt;
    logic [DEPTH-1:0]   r_lane [LINE_W];
    logic               w_accept;
    logic               w_lane_hs;

    assign w_accept  = in_valid && in_ready;
    assign w_lane_hs = out_valid && out_ready;

    // State register; reset aborts any partial frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and handshake/status decode, all from registered state.
    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_FILL;
                end
            end
            S_FILL: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid && (r_slice_cnt == CNT_W'(DEPTH - 1))) begin
                    w_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                if (out_ready && (r_lane_cnt == 5'(LINE_W - 1))) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Slice and lane counters; cleared on reset and on frame start.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_slice_cnt <= '0;
            r_lane_cnt  <= '0;
        end else if ((r_state == S_IDLE) && start) begin
            r_slice_cnt <= '0;
            r_lane_cnt  <= '0;
        end else begin
            if (w_accept) begin
                r_slice_cnt <= r_slice_cnt + 1'b1;
            end
            if (w_lane_hs) begin
                r_lane_cnt <= r_lane_cnt + 1'b1;
            end
        end
    end

    // Transpose: bit j of each accepted slice lands at column slice_cnt of lane j.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned j = 0; j < LINE_W; j++) begin
                r_lane[j] <= '0;
            end
        end else if (w_accept) begin
            for (int unsigned j = 0; j < LINE_W; j++) begin
                r_lane[j][r_slice_cnt] <= in_line[j];
            end
        end
    end

    // Lane output mux; forced to zero outside DRAIN.
    always_comb begin
        out_lane = '0;
        for (int unsigned j = 0; j < LINE_W; j++) begin
            if (out_valid && (r_lane_cnt == 5'(j))) begin
                out_lane = r_lane[j];
            end
        end
    end

    assign out_idx = out_valid ? r_lane_cnt : '0;

`ifdef SLICE_PARITY_EN
    logic r_parity_err;

    // Sticky even-parity error; cleared by reset or an accepted start.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_parity_err <= 1'b0;
        end else if ((r_state == S_IDLE) && start) begin
            r_parity_err <= 1'b0;
        end else if (w_accept && ((^in_line) != in_parity)) begin
            r_parity_err <= 1'b1;
        end
    end

    assign parity_err = r_parity_err;
`endif

endmodule

// File: tb/tb_slice_to_lane_collector.sv
// Self-checking bench for slice_to_lane_collector: accepted slices feed a
// transpose model that queues expected lanes; a monitor pops and compares.
`timescale 1ns/1ps
module tb_slice_to_lane_collector;

    localparam int unsigned LW = 25;
    localparam int unsigned DP = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          in_valid;
    logic [LW-1:0] in_line;
    logic          in_ready;
    logic          out_valid;
    logic [DP-1:0] out_lane;
    logic [4:0]    out_idx;
    logic          out_ready;
    logic          busy;
    logic          done;
`ifdef SLICE_PARITY_EN
    logic          in_parity;
    logic          parity_err;
`endif

    always #5 clk = ~clk;

    slice_to_lane_collector #(.LINE_W(LW), .DEPTH(DP)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_line   (in_line),
`ifdef SLICE_PARITY_EN
        .in_parity (in_parity),
        .parity_err(parity_err),
`endif
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_lane  (out_lane),
        .out_idx   (out_idx),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    typedef struct {
        logic [4:0]    idx;
        logic [DP-1:0] lane;
    } exp_t;

    exp_t          exp_q[$];
    logic [LW-1:0] frame_q[$];

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int unsigned cyc = 0;
    int unsigned done_seen = 0;
    int unsigned rdy_mode = 0;
    int unsigned stall_left = 0;
    logic        prev_done = 1'b0;
    logic        perr_exp = 1'b0;
    int unsigned t_start = 0;
    int unsigned frames_expected = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    // Reference model: transpose each completed frame of accepted slices.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && in_valid && in_ready) begin
            frame_q.push_back(in_line);
            if (frame_q.size() == DP) begin
                for (int j = 0; j < LW; j++) begin
                    e.idx  = 5'(j);
                    e.lane = '0;
                    for (int s = 0; s < DP; s++) e.lane[s] = frame_q[s][j];
                    exp_q.push_back(e);
                end
                frame_q.delete();
            end
        end
    end

    // Monitor: compare presented lanes against the scoreboard head.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid) begin
                check("lane_expected", (exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    check("out_idx", out_idx, exp_q[0].idx);
                    check("out_lane", out_lane, exp_q[0].lane);
                    if (out_ready) void'(exp_q.pop_front());
                end
            end else begin
                check("out_lane_quiet", out_lane, 0);
            end
            if (done) begin
                done_seen++;
                check("done_width", prev_done, 0);
                check("lanes_left_at_done", exp_q.size(), 0);
            end
        end
        prev_done = done;
    end

    // Downstream ready generator.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0: out_ready = 1'b1;
                1: out_ready = ($urandom_range(0, 3) != 0);
                default: begin
                    if (out_valid && out_idx == 5'd7 && stall_left > 0) begin
                        out_ready = 1'b0;
                        stall_left--;
                    end else begin
                        out_ready = 1'b1;
                    end
                end
            endcase
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_lane"}, out_lane, 0);
        check({tag, "_out_idx"}, out_idx, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
`ifdef SLICE_PARITY_EN
        check({tag, "_parity_err"}, parity_err, perr_exp);
`endif
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; in_valid = 1'b0;
        tick(); tick();
        rst = 1'b0;
        frame_q.delete();
        exp_q.delete();
        perr_exp = 1'b0;
        @(negedge clk);
        check_quiet("reset");
        tick();
    endtask

    function automatic logic [LW-1:0] gen_slice(input int kind, input int s);
        logic [LW-1:0] one;
        one = 1;
        case (kind)
            0: return one << (s % LW);
            1: return '1;
            2: return (s % 2 != 0) ? '1 : '0;
            default: return LW'($urandom);
        endcase
    endfunction

    task automatic do_start();
        start = 1'b1;
        t_start = cyc;
        @(negedge clk);
        check("ready_before_start", in_ready, 0);
        check("busy_before_start", busy, 0);
        tick();
        start = 1'b0;
        perr_exp = 1'b0;
    endtask

    task automatic feed(input int kind, input int gap, input int n, input int corrupt);
        int s = 0;
        int unsigned guard = 0;
        logic ph = 1'b1;
        logic acc;
        logic [LW-1:0] l;
        while (s < n && guard < 1000) begin
            l = gen_slice(kind, s);
            in_line = l;
            in_valid = (gap == 0) ? 1'b1 : (gap == 1) ? ph : 1'($urandom_range(0, 1));
            ph = ~ph;
`ifdef SLICE_PARITY_EN
            in_parity = (s == corrupt) ? ~(^l) : (^l);
`endif
            @(negedge clk);
            check("in_ready_fill", in_ready, 1);
            check("busy_fill", busy, 1);
`ifdef SLICE_PARITY_EN
            check("parity_err_fill", parity_err, perr_exp);
`endif
            acc = in_valid && in_ready;
            tick();
            if (acc) begin
                if (s == corrupt) perr_exp = 1'b1;
                s++;
            end
            guard++;
        end
        check("feed_completed", (s == n), 1);
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input bit timing, input bit pulse_start);
        int unsigned k = 0;
        bit got = 0;
        while (k < 3000 && !got) begin
            start = (pulse_start && k == 3) ? 1'b1 : 1'b0;
            @(negedge clk);
            if (k == 0) begin
                check("drain_in_ready", in_ready, 0);
                check("drain_first_valid", out_valid, 1);
            end
            check("busy_drain", busy, !done);
            if (done) begin
                got = 1;
                if (timing) check("done_cycle", cyc - t_start, 90);
`ifdef SLICE_PARITY_EN
                check("parity_err_done", parity_err, perr_exp);
`endif
            end
            tick();
            k++;
        end
        start = 1'b0;
        check("done_reached", got, 1);
        @(negedge clk);
        check_quiet("after_done");
        tick();
    endtask

    task automatic run_frame(input int kind, input int gap, input bit timing,
                             input bit pulse, input int corrupt);
        do_start();
        feed(kind, gap, DP, corrupt);
        wait_done(timing, pulse);
        frames_expected++;
    endtask

    initial begin
        int unsigned d0;
        rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_line = '0;
`ifdef SLICE_PARITY_EN
        in_parity = 1'b0;
`endif
        do_reset();

        rdy_mode = 0;
        run_frame(0, 0, 1'b1, 1'b0, -1);

        run_frame(1, 1, 1'b0, 1'b0, -1);

        rdy_mode = 2; stall_left = 10;
        run_frame(3, 0, 1'b0, 1'b0, -1);
        rdy_mode = 0;

        do_start();
        feed(3, 0, 30, -1);
        do_reset();
        d0 = done_seen;
        run_frame(2, 0, 1'b0, 1'b0, -1);
        repeat (4) tick();
        check("done_count_after_abort", done_seen - d0, 1);

        d0 = done_seen;
        run_frame(3, 0, 1'b0, 1'b1, -1);
        repeat (5) tick();
        check("done_count_start_ignored", done_seen - d0, 1);

        run_frame(3, 0, 1'b0, 1'b0, 40);
        run_frame(3, 2, 1'b0, 1'b0, -1);

        rdy_mode = 1;
        for (int f = 0; f < 4; f++) run_frame(3, 2, 1'b0, 1'b0, -1);
        rdy_mode = 0;

        repeat (3) tick();
        check("scoreboard_empty", exp_q.size(), 0);
        check("total_done", done_seen, frames_expected);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
